// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32 subset (LB, SB, ADD, AND, SLL, ORI, BNE).
// Steps FETCH/DECODE/EXEC/MEM/WB, drives ALU opcode, enables and memory handshakes.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src_b,
  output logic [2:0]  alu_op,
  output logic        retire,
  output logic        trap,
  output logic        trap_cause
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_BAD, C_LB, C_SB, C_ADD, C_AND, C_SLL, C_ORI, C_BNE
  } cls_t;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, state_next;
  cls_t            cls, dec_cls;
  logic [TO_W-1:0] wd;
  logic            wd_last;
  logic            waiting;
  logic            enter_wait;

  // Register/immediate fields are the datapath's concern, not the sequencer's.
  logic unused_bits;
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec_cls = C_BAD;
    unique case (instr[6:0])
      7'b0000011: if (instr[14:12] == 3'b000) dec_cls = C_LB;
      7'b0100011: if (instr[14:12] == 3'b000) dec_cls = C_SB;
      7'b0010011: if (instr[14:12] == 3'b110) dec_cls = C_ORI;
      7'b1100011: if (instr[14:12] == 3'b001) dec_cls = C_BNE;
      7'b0110011: begin
        if (instr[31:25] == 7'b0000000) begin
          unique case (instr[14:12])
            3'b000:  dec_cls = C_ADD;
            3'b111:  dec_cls = C_AND;
            3'b001:  dec_cls = C_SLL;
            default: dec_cls = C_BAD;
          endcase
        end
      end
      default: dec_cls = C_BAD;
    endcase
  end

  assign wd_last    = (wd == WD_LAST);
  assign waiting    = ((state == S_FETCH) && !imem_ready) || ((state == S_MEM) && !dmem_ready);
  assign enter_wait = ((state_next == S_FETCH) || (state_next == S_MEM)) && (state_next != state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cls        <= C_BAD;
      wd         <= '0;
      trap_cause <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) cls <= dec_cls;
      if (enter_wait)   wd <= '0;
      else if (waiting) wd <= wd + 1'b1;
      if ((state != S_TRAP) && (state_next == S_TRAP))
        trap_cause <= (state != S_DECODE);
    end
  end

  // A ready arriving on the last allowed wait cycle takes priority over the trap.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  if (imem_ready)   state_next = S_DECODE;
                else if (wd_last) state_next = S_TRAP;
      S_DECODE: state_next = (dec_cls == C_BAD) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        unique case (cls)
          C_LB, C_SB: state_next = S_MEM;
          C_BNE:      state_next = S_FETCH;
          default:    state_next = S_WB;
        endcase
      end
      S_MEM:    if (dmem_ready)   state_next = (cls == C_SB) ? S_FETCH : S_WB;
                else if (wd_last) state_next = S_TRAP;
      S_WB:     state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 3'b000;
    retire     = 1'b0;
    trap       = 1'b0;
    if ((state == S_EXEC) || (state == S_WB)) begin
      unique case (cls)
        C_LB, C_SB: begin alu_op = 3'b010; alu_src_b = 1'b1; end
        C_ADD:      begin alu_op = 3'b010; alu_src_b = 1'b0; end
        C_AND:      begin alu_op = 3'b000; alu_src_b = 1'b0; end
        C_SLL:      begin alu_op = 3'b100; alu_src_b = 1'b0; end
        C_ORI:      begin alu_op = 3'b001; alu_src_b = 1'b1; end
        C_BNE:      begin alu_op = 3'b110; alu_src_b = 1'b0; end
        default:    begin alu_op = 3'b000; alu_src_b = 1'b0; end
      endcase
    end
    unique case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      S_EXEC: begin
        if (cls == C_BNE) begin
          pc_write = ~zero;
          pc_src   = 1'b1;
          retire   = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = (cls == C_SB);
        alu_op    = 3'b010;
        alu_src_b = 1'b1;
        retire    = dmem_ready && (cls == C_SB);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == C_LB);
        retire     = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle packed output word checked
// against hand-computed expectations with immediate assertions.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        imem_req, imem_ready;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        ir_write, pc_write, pc_src, reg_write, mem_to_reg, alu_src_b;
  logic [2:0]  alu_op;
  logic        retire, trap, trap_cause;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LB  = 32'h00408283;
  localparam logic [31:0] I_BNE = 32'h00209463;
  localparam logic [31:0] I_SB  = 32'h00208023;
  localparam logic [31:0] I_ORI = 32'h0FF0E093;
  localparam logic [31:0] I_SLL = 32'h002091B3;
  localparam logic [31:0] I_AND = 32'h0020F1B3;

  multicycle_control #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .retire(retire), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  logic [14:0] outs;
  assign outs = {imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we, reg_write,
                 mem_to_reg, alu_src_b, alu_op, retire, trap, trap_cause};

  function automatic logic [14:0] o(bit imr, bit irw, bit pcw, bit pcs, bit dr, bit dwe,
                                    bit rw, bit m2r, bit asb, bit [2:0] aop,
                                    bit ret, bit trp, bit tc);
    return {imr, irw, pcw, pcs, dr, dwe, rw, m2r, asb, aop, ret, trp, tc};
  endfunction

  localparam logic [14:0] Z = '0;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string tag, input logic [14:0] exp);
    #1;
    n_chk++;
    assert (outs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, outs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    expect_o("rst_async", Z);
    @(posedge clk);
    #1;
    expect_o("rst_idle", Z);
    rst_n = 1'b1;
  endtask

  logic [14:0] f_rdy, f_wait, trap0, trap1;

  initial begin
    f_rdy  = o(1,1,1,0, 0,0,0,0,0, 3'b000, 0,0,0);
    f_wait = o(1,0,0,0, 0,0,0,0,0, 3'b000, 0,0,0);
    trap0  = o(0,0,0,0, 0,0,0,0,0, 3'b000, 0,1,0);
    trap1  = o(0,0,0,0, 0,0,0,0,0, 3'b000, 0,1,1);
    rst_n = 1'b0; instr = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;

    @(posedge clk); #1;
    expect_o("reset_idle", Z);
    rst_n = 1'b1;

    // 1: ADD, retires at cycle 4
    next(); imem_ready = 1'b1; instr = I_ADD; expect_o("add_fetch", f_rdy);
    next(); expect_o("add_decode", Z);
    next(); instr = '0; expect_o("add_exec", o(0,0,0,0, 0,0,0,0,0, 3'b010, 0,0,0));
    next(); expect_o("add_wb", o(0,0,0,0, 0,0,1,0,0, 3'b010, 1,0,0));

    // 2: LB, dmem_ready low 3 cycles (4th wait cycle would time out: ready wins)
    next(); instr = I_LB; expect_o("lb_fetch", f_rdy);
    next(); expect_o("lb_decode", Z);
    next(); expect_o("lb_exec", o(0,0,0,0, 0,0,0,0,1, 3'b010, 0,0,0));
    next(); dmem_ready = 1'b0; expect_o("lb_mem1", o(0,0,0,0, 1,0,0,0,1, 3'b010, 0,0,0));
    next(); expect_o("lb_mem2", o(0,0,0,0, 1,0,0,0,1, 3'b010, 0,0,0));
    next(); expect_o("lb_mem3", o(0,0,0,0, 1,0,0,0,1, 3'b010, 0,0,0));
    next(); dmem_ready = 1'b1; expect_o("lb_mem4", o(0,0,0,0, 1,0,0,0,1, 3'b010, 0,0,0));
    next(); dmem_ready = 1'b0; expect_o("lb_wb", o(0,0,0,0, 0,0,1,1,1, 3'b010, 1,0,0));

    // 3: BNE taken (with one fetch wait) and not taken
    next(); imem_ready = 1'b0; instr = I_BNE; expect_o("bne_fwait", f_wait);
    next(); imem_ready = 1'b1; expect_o("bne_fetch", f_rdy);
    next(); expect_o("bne_decode", Z);
    next(); zero = 1'b0; expect_o("bne_taken", o(0,0,1,1, 0,0,0,0,0, 3'b110, 1,0,0));
    next(); zero = 1'b1; expect_o("bne2_fetch", f_rdy);
    next(); expect_o("bne2_decode", Z);
    next(); expect_o("bne_nottaken", o(0,0,0,1, 0,0,0,0,0, 3'b110, 1,0,0));

    // 4: SB, ORI, SLL, AND
    next(); zero = 1'b0; instr = I_SB; expect_o("sb_fetch", f_rdy);
    next(); expect_o("sb_decode", Z);
    next(); expect_o("sb_exec", o(0,0,0,0, 0,0,0,0,1, 3'b010, 0,0,0));
    next(); dmem_ready = 1'b1; expect_o("sb_mem", o(0,0,0,0, 1,1,0,0,1, 3'b010, 1,0,0));
    next(); dmem_ready = 1'b0; instr = I_ORI; expect_o("ori_fetch", f_rdy);
    next(); expect_o("ori_decode", Z);
    next(); expect_o("ori_exec", o(0,0,0,0, 0,0,0,0,1, 3'b001, 0,0,0));
    next(); expect_o("ori_wb", o(0,0,0,0, 0,0,1,0,1, 3'b001, 1,0,0));
    next(); instr = I_SLL; expect_o("sll_fetch", f_rdy);
    next(); expect_o("sll_decode", Z);
    next(); expect_o("sll_exec", o(0,0,0,0, 0,0,0,0,0, 3'b100, 0,0,0));
    next(); expect_o("sll_wb", o(0,0,0,0, 0,0,1,0,0, 3'b100, 1,0,0));
    next(); instr = I_AND; expect_o("and_fetch", f_rdy);
    next(); expect_o("and_decode", Z);
    next(); expect_o("and_exec", o(0,0,0,0, 0,0,0,0,0, 3'b000, 0,0,0));
    next(); expect_o("and_wb", o(0,0,0,0, 0,0,1,0,0, 3'b000, 1,0,0));

    // 5a: illegal instruction, trap is sticky
    next(); instr = '0; expect_o("ill_fetch", f_rdy);
    next(); expect_o("ill_decode", Z);
    for (int i = 0; i < 100; i++) begin
      next();
      expect_o("ill_trap", trap0);
    end

    // 5b: memory timeout with TIMEOUT=4
    do_reset();
    next(); instr = I_LB; expect_o("to_fetch", f_rdy);
    next(); expect_o("to_decode", Z);
    next(); expect_o("to_exec", o(0,0,0,0, 0,0,0,0,1, 3'b010, 0,0,0));
    for (int i = 0; i < 4; i++) begin
      next();
      expect_o("to_mem_wait", o(0,0,0,0, 1,0,0,0,1, 3'b010, 0,0,0));
    end
    next(); expect_o("to_trap", trap1);
    next(); expect_o("to_trap_hold", trap1);

    // 6: asynchronous reset during MEM of SB
    do_reset();
    next(); instr = I_SB; expect_o("ar_fetch", f_rdy);
    next(); expect_o("ar_decode", Z);
    next(); expect_o("ar_exec", o(0,0,0,0, 0,0,0,0,1, 3'b010, 0,0,0));
    next(); expect_o("ar_mem", o(0,0,0,0, 1,1,0,0,1, 3'b010, 0,0,0));
    #1;
    do_reset();
    next(); imem_ready = 1'b0; expect_o("ar_refetch", f_wait);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
